// File: rtl/alpha_bp_pkg.sv
// Shared widths, counter reset values and saturating helpers for the tournament predictor.
package alpha_bp_pkg;

    localparam int unsigned PC_W    = 10;
    localparam int unsigned LHIST_W = 10;
    localparam int unsigned GHIST_W = 12;

    localparam int unsigned LCNT_W = 3;
    localparam int unsigned GCNT_W = 2;
    localparam int unsigned CCNT_W = 2;

    localparam logic [LCNT_W-1:0] LCNT_INIT = 3'd3;
    localparam logic [GCNT_W-1:0] GCNT_INIT = 2'd1;
    localparam logic [CCNT_W-1:0] CCNT_INIT = 2'd1;

    // Counter values at or above these thresholds mean taken / select-global.
    localparam logic [LCNT_W-1:0] LCNT_TAKEN = 3'd4;
    localparam logic [GCNT_W-1:0] GCNT_TAKEN = 2'd2;
    localparam logic [CCNT_W-1:0] CCNT_GLOBAL = 2'd2;

    // Counters are handled as 3-bit values; narrower tables zero-extend.
    function automatic logic [2:0] sat_inc(input logic [2:0] value, input logic [2:0] max_value);
        return (value == max_value) ? value : value + 3'd1;
    endfunction

    function automatic logic [2:0] sat_dec(input logic [2:0] value);
        return (value == 3'd0) ? value : value - 3'd1;
    endfunction

endpackage

// File: rtl/sat_counter_table.sv
// Array of saturating up/down counters with async reset-to-init and combinational read.
module sat_counter_table
    import alpha_bp_pkg::*;
#(
    parameter int unsigned      ADDR_W = 10,
    parameter int unsigned      WIDTH  = 3,
    parameter logic [WIDTH-1:0] INIT   = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data_c,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_up
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam logic [2:0]  MAX_V = 3'((1 << WIDTH) - 1);

    logic [WIDTH-1:0] mem [DEPTH];

    assign rd_data_c = mem[rd_addr];

    // Reset every entry to INIT; otherwise step one entry toward its limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[ADDR_W'(i)] <= INIT;
            end
        end else if (wr_en) begin
            if (wr_up) begin
                mem[wr_addr] <= WIDTH'(sat_inc(3'(mem[wr_addr]), MAX_V));
            end else begin
                mem[wr_addr] <= WIDTH'(sat_dec(3'(mem[wr_addr])));
            end
        end
    end

endmodule

// File: rtl/alpha_branch_predictor.sv
// Tournament predictor: local (LHT+LPT) vs global (GHR+GPT), arbitrated by CPT.
// Each branch is a fixed 8-edge transaction: predict at phase 0, update at phase 7.
module alpha_branch_predictor
    import alpha_bp_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic [PC_W-1:0] PC,
    input  logic            BranchTaken,
    output logic            PredictedBranch
);

    logic [2:0]         phase;
    logic [LHIST_W-1:0] lht [1 << PC_W];
    logic [GHIST_W-1:0] ghr;

    logic [LHIST_W-1:0] snap_lidx;
    logic [GHIST_W-1:0] snap_gidx;
    logic               snap_local;
    logic               snap_global;

    logic [LHIST_W-1:0] lht_cur_c;
    logic [LCNT_W-1:0]  lpt_rd_c;
    logic [GCNT_W-1:0]  gpt_rd_c;
    logic [CCNT_W-1:0]  cpt_rd_c;
    logic               local_p_c;
    logic               global_p_c;
    logic               final_p_c;
    logic               update_c;

    assign lht_cur_c  = lht[PC];
    assign local_p_c  = (lpt_rd_c >= LCNT_TAKEN);
    assign global_p_c = (gpt_rd_c >= GCNT_TAKEN);
    assign final_p_c  = (cpt_rd_c >= CCNT_GLOBAL) ? global_p_c : local_p_c;
    assign update_c   = (phase == 3'd7);

    sat_counter_table #(.ADDR_W(LHIST_W), .WIDTH(LCNT_W), .INIT(LCNT_INIT)) u_lpt (
        .clk       (clock),
        .rst_n     (reset),
        .rd_addr   (lht_cur_c),
        .rd_data_c (lpt_rd_c),
        .wr_en     (update_c),
        .wr_addr   (snap_lidx),
        .wr_up     (BranchTaken)
    );

    sat_counter_table #(.ADDR_W(GHIST_W), .WIDTH(GCNT_W), .INIT(GCNT_INIT)) u_gpt (
        .clk       (clock),
        .rst_n     (reset),
        .rd_addr   (ghr),
        .rd_data_c (gpt_rd_c),
        .wr_en     (update_c),
        .wr_addr   (snap_gidx),
        .wr_up     (BranchTaken)
    );

    // Choice moves only on disagreement, toward whichever side was right.
    sat_counter_table #(.ADDR_W(GHIST_W), .WIDTH(CCNT_W), .INIT(CCNT_INIT)) u_cpt (
        .clk       (clock),
        .rst_n     (reset),
        .rd_addr   (ghr),
        .rd_data_c (cpt_rd_c),
        .wr_en     (update_c && (snap_local != snap_global)),
        .wr_addr   (snap_gidx),
        .wr_up     (snap_global == BranchTaken)
    );

    // Phase sequencing, registered prediction and phase-0 snapshot of indices/votes.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            phase           <= 3'd0;
            PredictedBranch <= 1'b0;
            snap_lidx       <= '0;
            snap_gidx       <= '0;
            snap_local      <= 1'b0;
            snap_global     <= 1'b0;
        end else begin
            phase <= phase + 3'd1;
            if (phase == 3'd0) begin
                PredictedBranch <= final_p_c;
                snap_lidx       <= lht_cur_c;
                snap_gidx       <= ghr;
                snap_local      <= local_p_c;
                snap_global     <= global_p_c;
            end
        end
    end

    // Shift the resolved outcome into the branch's local history.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < (1 << PC_W); i++) begin
                lht[PC_W'(i)] <= '0;
            end
        end else if (update_c) begin
            lht[PC] <= {lht_cur_c[LHIST_W-2:0], BranchTaken};
        end
    end

    // Shift the resolved outcome into the global path history.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ghr <= '0;
        end else if (update_c) begin
            ghr <= {ghr[GHIST_W-2:0], BranchTaken};
        end
    end

endmodule

// File: tb/tb_alpha_branch_predictor.sv
// Directed bench for alpha_branch_predictor with a behavioural reference model.
module tb_alpha_branch_predictor;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [9:0] PC = '0;
    logic       BranchTaken = 1'b0;
    logic       PredictedBranch;

    int unsigned total  = 0;
    int unsigned passed = 0;

    bit exp_q[$];

    int m_lht [1024];
    int m_lpt [1024];
    int m_gpt [4096];
    int m_cpt [4096];
    int m_ghr;

    alpha_branch_predictor dut (
        .clock           (clock),
        .reset           (reset),
        .PC              (PC),
        .BranchTaken     (BranchTaken),
        .PredictedBranch (PredictedBranch)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 1024; i++) begin
            m_lht[i] = 0;
            m_lpt[i] = 3;
        end
        for (int i = 0; i < 4096; i++) begin
            m_gpt[i] = 1;
            m_cpt[i] = 1;
        end
        m_ghr = 0;
    endtask

    function automatic bit model_predict(input int pc);
        bit lp;
        bit gp;
        lp = (m_lpt[m_lht[pc]] > 3);
        gp = (m_gpt[m_ghr] > 1);
        return (m_cpt[m_ghr] > 1) ? gp : lp;
    endfunction

    task automatic model_update(input int pc, input bit t);
        int  li;
        int  gi;
        bit  lp;
        bit  gp;
        li = m_lht[pc];
        gi = m_ghr;
        lp = (m_lpt[li] > 3);
        gp = (m_gpt[gi] > 1);
        if (t) begin
            if (m_lpt[li] < 7) m_lpt[li] = m_lpt[li] + 1;
            if (m_gpt[gi] < 3) m_gpt[gi] = m_gpt[gi] + 1;
        end else begin
            if (m_lpt[li] > 0) m_lpt[li] = m_lpt[li] - 1;
            if (m_gpt[gi] > 0) m_gpt[gi] = m_gpt[gi] - 1;
        end
        if (lp != gp) begin
            if (gp == t) begin
                if (m_cpt[gi] < 3) m_cpt[gi] = m_cpt[gi] + 1;
            end else begin
                if (m_cpt[gi] > 0) m_cpt[gi] = m_cpt[gi] - 1;
            end
        end
        m_lht[pc] = ((m_lht[pc] << 1) | int'(t)) & 1023;
        m_ghr     = ((m_ghr << 1) | int'(t)) & 4095;
    endtask

    // One full transaction; entered just after a falling edge with phase 0 pending.
    task automatic run_txn(input logic [9:0] pc, input bit t);
        bit expd;
        PC = pc;
        BranchTaken = ~t;
        exp_q.push_back(model_predict(int'(pc)));
        @(posedge clock);
        #1;
        expd = exp_q.pop_front();
        check("pred", 32'(PredictedBranch), 32'(expd));
        repeat (6) @(posedge clock);
        @(negedge clock);
        check("pred_hold", 32'(PredictedBranch), 32'(expd));
        BranchTaken = t;
        @(posedge clock);
        model_update(int'(pc), t);
        @(negedge clock);
    endtask

    initial begin
        model_reset();
        reset = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        check("reset_pred", 32'(PredictedBranch), 32'd0);
        check("reset_phase", 32'(dut.phase), 32'd0);
        @(negedge clock);
        reset = 1'b1;

        // PC 0 always taken: local learns after history saturates at 1023.
        for (int i = 1; i <= 20; i++) begin
            run_txn(10'd0, 1'b1);
            check("pc0_pattern", 32'(PredictedBranch), (i >= 12) ? 32'd1 : 32'd0);
            if (i == 12) begin
                check("cpt2047", 32'(dut.u_cpt.mem[2047]), 32'd0);
            end
            if (i == 13) begin
                check("cpt4095", 32'(dut.u_cpt.mem[4095]), 32'd0);
                check("gpt4095", 32'(dut.u_gpt.mem[4095]), 32'd2);
                check("ghr_ones", 32'(dut.ghr), 32'd4095);
            end
        end
        check("lht0_ones", 32'(dut.lht[0]), 32'd1023);
        check("lpt1023_sat7", 32'(dut.u_lpt.mem[1023]), 32'd7);

        // Reset in phase 5 aborts the transaction and restores init state.
        PC = 10'd0;
        BranchTaken = 1'b1;
        @(posedge clock);
        #1;
        check("pre_abort_pred", 32'(PredictedBranch), 32'(model_predict(0)));
        repeat (4) @(posedge clock);
        @(negedge clock);
        check("abort_at_phase5", 32'(dut.phase), 32'd5);
        reset = 1'b0;
        #1;
        check("abort_pred", 32'(PredictedBranch), 32'd0);
        check("abort_phase", 32'(dut.phase), 32'd0);
        check("abort_ghr", 32'(dut.ghr), 32'd0);
        check("abort_lht0", 32'(dut.lht[0]), 32'd0);
        check("abort_lpt1023", 32'(dut.u_lpt.mem[1023]), 32'd3);
        check("abort_cpt4095", 32'(dut.u_cpt.mem[4095]), 32'd1);
        check("abort_gpt4095", 32'(dut.u_gpt.mem[4095]), 32'd1);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        model_reset();
        run_txn(10'd0, 1'b1);
        check("post_abort_first", 32'(PredictedBranch), 32'd0);

        // Interleaved PCs with opposite outcomes keep separate histories.
        for (int i = 0; i < 12; i++) begin
            run_txn(10'd5, 1'b1);
            run_txn(10'd9, 1'b0);
        end
        check("lht5_ones", 32'(dut.lht[5]), 32'd1023);
        check("lht9_zero", 32'(dut.lht[9]), 32'd0);
        check("lht0_untouched", 32'(dut.lht[0]), 32'd1);
        check("lpt0_model", 32'(dut.u_lpt.mem[0]), 32'(m_lpt[0]));
        check("lpt1023_model", 32'(dut.u_lpt.mem[1023]), 32'(m_lpt[1023]));

        // Not-taken updates floor LPT[0] at 0.
        for (int i = 0; i < 8; i++) begin
            run_txn(10'd9, 1'b0);
        end
        check("lpt0_sat0", 32'(dut.u_lpt.mem[0]), 32'd0);
        check("ghr_model", 32'(dut.ghr), 32'(m_ghr));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/alpha_branch_predictor.md
Name: alpha_branch_predictor

Overview:
- Alpha-21264-style tournament branch predictor for a 10-bit PC.
- A local predictor (per-branch history plus 3-bit counters) and a global predictor (path history plus 2-bit counters) compete; a choice predictor selects between them.
- Each branch is one fixed 8-cycle transaction: prediction phase, then resolution/update phase.
- No handshake signals; the sequence is timed by an internal phase counter.

Parameters:
- PC_W, 10, PC/index width; local history table depth = 2**PC_W.
- LHIST_W, 10, local history bits; local prediction table depth = 2**LHIST_W.
- GHIST_W, 12, global history bits; global and choice table depth = 2**GHIST_W.

Ports:
- clock  input  1  single system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- PC  input  10  branch address; must be stable for the whole 8-cycle transaction.
- BranchTaken  input  1  resolved outcome (1 = taken); sampled only at the update edge.
- PredictedBranch  output  1  registered prediction (1 = taken).

Behaviour:
- State:
  - LHT: 1024 x 10-bit local histories, indexed by PC.
  - LPT: 1024 x 3-bit saturating counters, indexed by LHT[PC].
  - GHR: 12-bit global history register.
  - GPT: 4096 x 2-bit counters, indexed by GHR.
  - CPT: 4096 x 2-bit choice counters, indexed by GHR.
  - phase: 3-bit counter.
- Reset (asynchronous, reset==0):
  - phase=0, PredictedBranch=0, GHR=0.
  - All LHT entries 0; all LPT entries 3'd3 (weak not-taken).
  - All GPT entries 2'd1 (weak not-taken); all CPT entries 2'd1 (weak select-local).
  - Reset asserted mid-transaction aborts it with no table update.
- Phase counter: increments by 1 on every rising edge out of reset and wraps 7->0. A transaction starts at the first edge after reset deasserts.
- Prediction, combinational from current state:
  - local_p = LPT[LHT[PC]][2]
  - global_p = GPT[GHR][1]
  - final = CPT[GHR][1] ? global_p : local_p
- Edge with phase==0 (first edge of a transaction):
  - PredictedBranch <= final.
  - local_p, global_p and the LHT/GHR indices are snapshotted into internal registers.
  - PredictedBranch holds until the next phase-0 edge (latency: 1 edge after transaction start).
- Edge with phase==7 (update), with t = BranchTaken:
  - LPT[snap LHT]: saturating +1 if t, else -1 (range 0..7).
  - GPT[snap GHR]: saturating +1 if t, else -1 (range 0..3).
  - CPT[snap GHR], only when local_p != global_p: +1 (saturate at 3) if global_p==t; -1 (saturate at 0) if local_p==t. Unchanged when the two predictions agree.
  - LHT[PC] <= {LHT[PC][8:0], t}.
  - GHR <= {GHR[10:0], t}.
- All table reads use pre-update values. Same-edge read/write conflicts do not arise, because reads are snapshotted at phase 0.
- Counters never wrap past 0 or their maximum.

Decomposition:
- Package alpha_bp_pkg holds:
  - width constants PC_W, LHIST_W, GHIST_W;
  - counter reset constants LCNT_INIT=3'd3, GCNT_INIT=2'd1, CCNT_INIT=2'd1;
  - saturating increment/decrement functions.
- One sub-module, sat_counter_table: a parameterised depth x width array with asynchronous reset-to-init, combinational read, and a saturating up/down write port. It is instantiated for LPT, GPT and CPT.

Test Plan:
- Reset for 4 cycles with reset=0 -> PredictedBranch=0, phase=0; after release, the first transaction predicts 0 (LPT=3, GPT=1, choice selects local).
- PC=0, BranchTaken=1 held from phase 4 through phase 7, repeated 20 transactions -> PredictedBranch=0 for transactions 1-11 and 1 for transactions 12-20. In transaction 12, LHT[0]=1023, LPT[1023]=4 and CPT[2047]=1 selects local.
- Same run, after transaction 13 -> CPT[4095]=0 (local correct, global wrong); GPT[4095]=2; GHR=4095.
- Alternate PC=5 taken and PC=9 not-taken, 12 transactions each -> LHT[5]=all-ones and LHT[9]=0; each PC's LPT counters move independently with no cross-PC interference.
- Assert reset at phase 5 of a transaction -> no update occurs, all tables return to init values, PredictedBranch=0, and a new transaction starts after release.
- Drive a counter to its limit (e.g. 8 consecutive taken updates on one LPT entry) -> the entry saturates at 7 and does not wrap; 8 not-taken updates saturate it at 0.
